// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM state type and default operand width for serial_adder
package serial_adder_pkg;
  localparam int WIDTH_DEF = 8;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/full_adder_bit.sv
// full_adder_bit: one-bit combinational full adder used as the serial datapath
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial a+b+cin over WIDTH cycles with valid/ready handshakes.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             done_valid,
  input  logic             done_ready,
  output logic             busy
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int CW = $clog2(WIDTH);
  state_t state, state_nx;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic [CW-1:0] cnt;
  logic c, fa_s, fa_c, last;
  full_adder_bit u_fa (.a(a_sr[0]), .b(b_sr[0]), .cin(c), .s(fa_s), .cout(fa_c));
  assign last = cnt == CW'(WIDTH - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // unused encoding falls back to IDLE
  always_comb begin
    state_nx    = state == IDLE ? (start_valid ? RUN : IDLE) :
                  state == RUN  ? (last ? DONE : RUN) :
                  state == DONE ? (done_ready ? IDLE : DONE) : IDLE;
    start_ready = state == IDLE;
    done_valid  = state == DONE;
    busy        = state == RUN || state == DONE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_sr <= '0;
      b_sr <= '0;
      c    <= 1'b0;
      cnt  <= '0;
      sum  <= '0;
      cout <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf  <= 1'b0;
`endif
    end else if (state == IDLE && start_valid) begin
      a_sr <= a;
      b_sr <= b;
      c    <= cin;
      cnt  <= '0;
    end else if (state == RUN) begin
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      c    <= fa_c;
      cnt  <= cnt + CW'(1);
      sum  <= {fa_s, sum[WIDTH-1:1]};
      if (last) cout <= fa_c;
`ifdef SERIAL_ADDER_OVF_EN
      // c holds the carry into the MSB on the final step
      if (last) ovf <= c ^ fa_c;
`endif
    end
endmodule
